// File: rtl/ram_read_streamer.sv
// rtl/ram_read_streamer.sv - burst reader: RAM read pipeline into a small FIFO with a valid/ready stream out
// Optional feature: define RAM_READ_STREAMER_ABORT_EN to add the abort input.
module ram_read_streamer #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 9,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  rclk,
  input  logic                  rst,
`ifdef RAM_READ_STREAMER_ABORT_EN
  input  logic                  abort,
`endif
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic                  re,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           fifo_count;
  logic [CW-1:0]           inflight;
  logic [READ_LATENCY-1:0] track;
  logic [ADDR_WIDTH:0]     len_q, issue_left, beat_cnt;
  logic                    push, pop, last_xfer, abort_req;

  // Credit check counts reads still in the RAM pipe so the FIFO can always absorb them
  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + CW'(track[i]);
`ifdef RAM_READ_STREAMER_ABORT_EN
    abort_req = abort && (state == ISSUE || state == DRAIN);
`else
    abort_req = 1'b0;
`endif
    re        = (state == ISSUE) && !abort_req && ((inflight + fifo_count) < CW'(FIFO_DEPTH));
    push      = track[READ_LATENCY-1];
    m_valid   = (fifo_count != '0);
    pop       = m_valid && m_ready;
    m_data    = m_valid ? mem[rd_ptr] : '0;
    m_last    = m_valid && (beat_cnt == len_q - 1'b1);
    last_xfer = pop && m_last;
  end

  // Read tracking pipe and FIFO pointers; reset and abort both discard everything in flight
  always_ff @(posedge rclk) begin
    if (rst || abort_req) begin
      track      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      track[0] <= re;
      for (int i = 1; i < READ_LATENCY; i++) track[i] <= track[i-1];
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage, written when a tracked read's data emerges from the RAM
  always_ff @(posedge rclk) begin
    if (push) mem[wr_ptr] <= rdata;
  end

  // Burst control FSM with registered busy/done
  always_ff @(posedge rclk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      raddr      <= '0;
      len_q      <= '0;
      issue_left <= '0;
      beat_cnt   <= '0;
    end else begin
      done <= 1'b0;
      if (pop) beat_cnt <= beat_cnt + 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            len_q      <= length;
            issue_left <= length;
            raddr      <= start_addr;
            beat_cnt   <= '0;
            if (length == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= ISSUE;
              busy  <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (abort_req) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (re) begin
            raddr      <= raddr + 1'b1;
            issue_left <= issue_left - 1'b1;
            if (issue_left == (ADDR_WIDTH+1)'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (abort_req || last_xfer) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_read_streamer.sv
// tb/tb_ram_read_streamer.sv - randomized self-checking bench for ram_read_streamer
module tb_ram_read_streamer;
  localparam int DW = 8, AW = 9, RL = 2, FD = 4, DEPTH = 512;

  logic          rclk = 1'b0, rst = 1'b1, start = 1'b0, m_ready = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   length = '0;
  logic          busy, done, re, m_valid, m_last;
  logic [AW-1:0] raddr;
  logic [DW-1:0] m_data;
  logic [DW-1:0] rdata = '0, ram_p1 = '0;
  logic [DW-1:0] ram [DEPTH];
`ifdef RAM_READ_STREAMER_ABORT_EN
  logic          abort = 1'b0;
`endif
  int checks = 0, failures = 0;

  ram_read_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(RL), .FIFO_DEPTH(FD)) dut (
    .rclk(rclk), .rst(rst),
`ifdef RAM_READ_STREAMER_ABORT_EN
    .abort(abort),
`endif
    .start(start), .start_addr(start_addr), .length(length),
    .busy(busy), .done(done), .raddr(raddr), .re(re), .rdata(rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  always #5 rclk = ~rclk;

  // Two-cycle RAM: address registered on re, output register always on
  always @(posedge rclk) begin
    if (re) ram_p1 <= ram[raddr];
    rdata <= ram_p1;
  end

  task automatic next_cycle();
    @(posedge rclk);
    #1;
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || re !== 1'b0 || raddr !== '0 ||
        m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== '0) begin
      failures++;
      $display("FAIL %s got busy=%b done=%b re=%b raddr=%0h m_valid=%b m_last=%b m_data=%0h exp all zero",
               name, busy, done, re, raddr, m_valid, m_last, m_data);
    end
  endtask

  // One burst against the reference: word i comes from ram[(addr+i) mod DEPTH],
  // FIFO occupancy = reads issued more than RL cycles ago minus beats taken.
  task automatic run_burst(input logic [AW-1:0] addr, input int len, input int mode,
                           input int abort_after, input bit extra_start, input string name);
    int n_re = 0, n_beat = 0, done_cnt = 0, done_c = -1, first_valid = -1;
    int last_beat_c = -1, abort_c = -1, limit, occ;
    int re_c[$];
    bit prev_stall = 0, aborted = 0;
    logic [DW-1:0] prev_data = '0, exp_data;
    logic prev_last = 1'b0;
    limit = 30 * len + 60;
    next_cycle();
    start = 1'b1; start_addr = addr; length = (AW+1)'(len); m_ready = 1'b0;
    for (int c = 1; c <= limit; c++) begin
      next_cycle();
      start = 1'b0;
      if (extra_start && c == 2) begin
        start = 1'b1; start_addr = ~addr; length = 3;
      end
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ((c - 1) % 3 == 0);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
`ifdef RAM_READ_STREAMER_ABORT_EN
      abort = 1'b0;
      if (abort_after > 0 && !aborted && n_beat == abort_after) begin
        abort = 1'b1; m_ready = 1'b0; aborted = 1; abort_c = c;
      end
`endif
      #1;
      if (c == 1) begin
        checks++;
        if (re !== 1'b1 || raddr !== addr) begin
          failures++;
          $display("FAIL %s first_re got re=%b raddr=%0h exp re=1 raddr=%0h", name, re, raddr, addr);
        end
      end
      if (aborted && c > abort_c) begin
        checks++;
        if (re !== 1'b0 || m_valid !== 1'b0) begin
          failures++;
          $display("FAIL %s after_abort c=%0d got re=%b m_valid=%b exp 0 0", name, c, re, m_valid);
        end
      end else begin
        if (re === 1'b1) begin
          checks++;
          if (n_re >= len || raddr !== AW'(addr + n_re)) begin
            failures++;
            $display("FAIL %s raddr idx=%0d got=%0h exp=%0h (len %0d)", name, n_re, raddr, AW'(addr + n_re), len);
          end
          re_c.push_back(c);
          n_re++;
        end
        occ = -n_beat;
        foreach (re_c[i]) if (re_c[i] <= c - RL - 1) occ++;
        checks++;
        if (occ > FD || m_valid !== (occ > 0)) begin
          failures++;
          $display("FAIL %s occupancy c=%0d got m_valid=%b exp occ=%0d (max %0d)", name, c, m_valid, occ, FD);
        end
        if (m_valid === 1'b1) begin
          if (first_valid < 0) first_valid = c;
          if (prev_stall) begin
            checks++;
            if (m_data !== prev_data || m_last !== prev_last) begin
              failures++;
              $display("FAIL %s stall_stable got data=%0h last=%b exp data=%0h last=%b",
                       name, m_data, m_last, prev_data, prev_last);
            end
          end
          exp_data = ram[AW'(addr + n_beat)];
          checks++;
          if (m_data !== exp_data || m_last !== (n_beat == len - 1)) begin
            failures++;
            $display("FAIL %s beat %0d got data=%0h last=%b exp data=%0h last=%b",
                     name, n_beat, m_data, m_last, exp_data, (n_beat == len - 1));
          end
          if (m_ready) begin
            n_beat++;
            last_beat_c = c;
          end
        end
      end
      prev_stall = (m_valid === 1'b1) && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_c < 0) done_c = c;
      end
      checks++;
      if (busy !== (done_cnt == 0)) begin
        failures++;
        $display("FAIL %s busy c=%0d got=%b exp=%b", name, c, busy, (done_cnt == 0));
      end
      if (done_c >= 0 && c >= done_c + 3) break;
    end
    m_ready = 1'b0;
    checks++;
    if (done_cnt != 1) begin
      failures++;
      $display("FAIL %s done_pulses got=%0d exp=1", name, done_cnt);
    end
    checks++;
    if (done_c != (aborted ? abort_c + 1 : last_beat_c + 1)) begin
      failures++;
      $display("FAIL %s done_cycle got=%0d exp=%0d", name, done_c, aborted ? abort_c + 1 : last_beat_c + 1);
    end
    checks++;
    if (aborted ? (n_beat != abort_after) : (n_re != len || n_beat != len)) begin
      failures++;
      $display("FAIL %s counts got reads=%0d beats=%0d exp len=%0d abort_after=%0d",
               name, n_re, n_beat, len, abort_after);
    end
    if (mode == 0 && !aborted) begin
      checks++;
      if (first_valid != 2 + RL || last_beat_c != 1 + RL + len) begin
        failures++;
        $display("FAIL %s throughput got first=%0d last=%0d exp first=%0d last=%0d",
                 name, first_valid, last_beat_c, 2 + RL, 1 + RL + len);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) next_cycle();
    check_idle_outputs("reset");
    rst = 1'b0;
    next_cycle();
    check_idle_outputs("after_reset");
  endtask

  task automatic test_latency();
    run_burst(9'h010, 4, 0, 0, 0, "latency");
  endtask

  task automatic test_wrap();
    run_burst(9'h1FE, 4, 2, 0, 0, "wrap");
  endtask

  task automatic test_backpressure();
    run_burst(AW'($urandom_range(0, DEPTH - 1)), 16, 1, 0, 0, "backpressure");
  endtask

  task automatic test_zero_length();
    next_cycle();
    start = 1'b1; start_addr = 9'h055; length = '0;
    for (int c = 1; c <= 6; c++) begin
      next_cycle();
      start = 1'b0;
      #1;
      checks++;
      if (done !== (c == 1) || busy !== 1'b0 || re !== 1'b0 || m_valid !== 1'b0) begin
        failures++;
        $display("FAIL zero_length c=%0d got done=%b busy=%b re=%b m_valid=%b exp done=%b others 0",
                 c, done, busy, re, m_valid, (c == 1));
      end
    end
  endtask

  task automatic test_busy_start();
    run_burst(AW'($urandom_range(0, DEPTH - 1)), 12, 2, 0, 1, "busy_start");
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++)
      run_burst(AW'($urandom_range(0, DEPTH - 1)), $urandom_range(1, 40), $urandom_range(0, 2), 0, 0, "random");
    run_burst(AW'($urandom_range(0, DEPTH - 1)), DEPTH, 2, 0, 0, "full_depth");
  endtask

  task automatic test_reset_mid_burst();
    next_cycle();
    start = 1'b1; start_addr = AW'($urandom_range(0, DEPTH - 1)); length = 4; m_ready = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      next_cycle();
      start = 1'b0;
    end
    #1;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_busy got=%b exp=1", busy);
    end
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    #1;
    check_idle_outputs("mid_reset_outputs");
    for (int c = 0; c < 8; c++) begin
      next_cycle();
      #1;
      checks++;
      if (m_valid !== 1'b0 || re !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("FAIL mid_reset_quiet got m_valid=%b re=%b busy=%b done=%b exp 0 0 0 0",
                 m_valid, re, busy, done);
      end
    end
    m_ready = 1'b0;
  endtask

`ifdef RAM_READ_STREAMER_ABORT_EN
  task automatic test_abort();
    run_burst(AW'($urandom_range(0, DEPTH - 1)), 10, 0, 3, 0, "abort");
  endtask
`endif

  initial begin
    foreach (ram[i]) ram[i] = DW'($urandom);
    test_reset();
    test_latency();
    test_wrap();
    test_backpressure();
    test_zero_length();
    test_busy_start();
    test_random();
    test_reset_mid_burst();
`ifdef RAM_READ_STREAMER_ABORT_EN
    test_abort();
`endif
    test_latency();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
